pattern_gen: RTL



---
 rtl/video_pkg.sv | 41 ++++
 rtl/bounce_pos.sv | 33 +++
 rtl/pattern_gen.sv | 125 ++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: active geometry, colour depth,
// pattern codes and the colour-bar index helper.
package video_pkg;

  localparam int ACTIVE_COLS = 640;
  localparam int ACTIVE_ROWS = 480;
  localparam int COLOR_BITS  = 3;

  typedef enum logic [2:0] {
    PAT_BLACK,
    PAT_RED,
    PAT_GREEN,
    PAT_BLUE,
    PAT_CHECKER,
    PAT_BARS,
    PAT_BORDER,
    PAT_SQUARE
  } pat_t;

  typedef logic [COLOR_BITS-1:0] chan_t;

  typedef struct packed {
    chan_t r;
    chan_t g;
    chan_t b;
  } rgb_t;

  // Bar number from threshold compares; avoids a divider.
  function automatic logic [2:0] bar_index(
    input logic [9:0] col,
    input int         cols
  );
    logic [2:0] k;
    k = '0;
    for (int i = 1; i < 8; i++) begin
      if (col >= 10'(i * (cols / 8))) k = 3'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/bounce_pos.sv
// One axis of the bouncing square: position 0..LIMIT,
// 1 px per step, reversing with a 1 px rebound at each end.
module bounce_pos #(
  parameter int LIMIT = 608
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       step,
  output logic [9:0] pos
);

  logic up;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos <= '0;
      up  <= 1'b1;
    end else if (step) begin
      if (up && pos == 10'(LIMIT)) begin
        up  <= 1'b0;
        pos <= pos - 10'd1;
      end else if (!up && pos == '0) begin
        up  <= 1'b1;
        pos <= pos + 10'd1;
      end else if (up) begin
        pos <= pos + 10'd1;
      end else begin
        pos <= pos - 10'd1;
      end
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// Test-pattern generator: per-frame pattern latch, bouncing
// square, two-stage colour/blank pipeline and sync re-delay.
module pattern_gen
  import video_pkg::*;
#(
  parameter int ACTIVE_COLS = video_pkg::ACTIVE_COLS,
  parameter int ACTIVE_ROWS = video_pkg::ACTIVE_ROWS,
  parameter int SQUARE      = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ihsync,
  input  logic       ivsync,
  input  logic [9:0] col,
  input  logic [9:0] row,
  input  logic [2:0] pattern_sel,
  output logic       ohsync,
  output logic       ovsync,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [2:0] blue
);

  logic       vs_q;
  logic       armed;
  logic       framestart;
  pat_t       active_pat;
  logic [9:0] sq_x;
  logic [9:0] sq_y;
  rgb_t       pix;
  rgb_t       pix_q;
  rgb_t       rgb_q;
  logic       act;
  logic       act_q;
  logic       in_sq;
  logic       on_edge;
  logic [2:0] bar;
  logic [1:0] hs_d;
  logic [1:0] vs_d;

  // armed blocks a framestart when vsync is already high at release
  assign framestart = ivsync & ~vs_q & armed;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vs_q       <= 1'b0;
      armed      <= 1'b0;
      active_pat <= PAT_BLACK;
    end else begin
      vs_q  <= ivsync;
      armed <= armed | ~ivsync;
      if (framestart) active_pat <= pat_t'(pattern_sel);
    end
  end

  bounce_pos #(.LIMIT(ACTIVE_COLS - SQUARE)) u_bx (
    .clock (clock),
    .reset (reset),
    .step  (framestart),
    .pos   (sq_x)
  );

  bounce_pos #(.LIMIT(ACTIVE_ROWS - SQUARE)) u_by (
    .clock (clock),
    .reset (reset),
    .step  (framestart),
    .pos   (sq_y)
  );

  assign act = (col < 10'(ACTIVE_COLS))
            && (row < 10'(ACTIVE_ROWS));

  assign in_sq = ({1'b0, col} >= {1'b0, sq_x})
              && ({1'b0, col} < {1'b0, sq_x} + 11'(SQUARE))
              && ({1'b0, row} >= {1'b0, sq_y})
              && ({1'b0, row} < {1'b0, sq_y} + 11'(SQUARE));

  assign on_edge = (col == '0)
                || (col == 10'(ACTIVE_COLS - 1))
                || (row == '0)
                || (row == 10'(ACTIVE_ROWS - 1));

  assign bar = bar_index(col, ACTIVE_COLS);

  always_comb begin
    pix = '0;
    unique case (active_pat)
      PAT_BLACK:   pix = '0;
      PAT_RED:     pix.r = '1;
      PAT_GREEN:   pix.g = '1;
      PAT_BLUE:    pix.b = '1;
      PAT_CHECKER: if (col[5] ^ row[5]) pix = '1;
      PAT_BARS: begin
        pix.r = {3{bar[2]}};
        pix.g = {3{bar[1]}};
        pix.b = {3{bar[0]}};
      end
      PAT_BORDER:  if (on_edge) pix = '1;
      PAT_SQUARE:  if (in_sq) pix = '1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_q <= '0;
      act_q <= 1'b0;
      rgb_q <= '0;
      hs_d  <= '0;
      vs_d  <= '0;
    end else begin
      pix_q <= pix;
      act_q <= act;
      rgb_q <= act_q ? pix_q : '0;
      hs_d  <= {hs_d[0], ihsync};
      vs_d  <= {vs_d[0], ivsync};
    end
  end

  assign red    = rgb_q.r;
  assign green  = rgb_q.g;
  assign blue   = rgb_q.b;
  assign ohsync = hs_d[1];
  assign ovsync = vs_d[1];

endmodule
